// File: rtl/eth_phy_10g_rx_prbs31_check_if.sv
// Raw 66-bit SERDES receive word (data + sync header) into the PRBS31 checker.
interface eth_phy_10g_rx_prbs31_check_if #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2
);
    logic [DATA_WIDTH-1:0] serdes_rx_data;
    logic [HDR_WIDTH-1:0]  serdes_rx_hdr;

    modport master (output serdes_rx_data, output serdes_rx_hdr);
    modport slave  (input  serdes_rx_data, input  serdes_rx_hdr);
endinterface

// File: rtl/eth_phy_10g_rx_prbs31_check.sv
// 10GBASE-R receive PRBS31 (x^31 + x^28 + 1) checker with lock hysteresis and error counting.
// Optional macro PRBS31_CHK_INVERT_EN: check against the inverted PRBS31 sequence.
//
// state       | meaning
// ST_UNLOCKED | counting consecutive error-free words towards LOCK_CNT
// ST_LOCKED   | pattern locked; counting consecutive errored words towards UNLOCK_CNT
module eth_phy_10g_rx_prbs31_check #(
    parameter int DATA_WIDTH    = 64,
    parameter int HDR_WIDTH     = 2,
    parameter int LOCK_CNT      = 16,
    parameter int UNLOCK_CNT    = 4,
    parameter int ERR_CNT_WIDTH = 32
) (
    input  logic                         rx_clk,
    input  logic                         rx_rst,
    input  logic                         cfg_rx_prbs31_enable,
    input  logic                         cfg_err_clear,
    eth_phy_10g_rx_prbs31_check_if.slave serdes_rx,
    output logic                         prbs_lock,
    output logic                         prbs_word_error,
    output logic [6:0]                   prbs_bit_error_count,
    output logic [ERR_CNT_WIDTH-1:0]     prbs_err_total
);
    localparam int W = DATA_WIDTH + HDR_WIDTH;

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t             state;
    logic [30:0]        hist;
    logic               primed;
    logic [7:0]         good_cnt;
    logic [7:0]         bad_cnt;

    logic [W-1:0]       stream;
    logic [W+30:0]      ext;
    logic [W-1:0]       err_vec;
    logic [6:0]         err_cnt;
    logic               word_err;
    logic [30:0]        hist_next;
    logic [ERR_CNT_WIDTH:0] sum;
    logic [ERR_CNT_WIDTH-1:0] total_next;

    // ext[0..30] are the previous 31 stream bits oldest-first, ext[31+p] is bit p of this word.
    always_comb begin
        stream = {serdes_rx.serdes_rx_data, serdes_rx.serdes_rx_hdr};
`ifdef PRBS31_CHK_INVERT_EN
        stream = ~stream;
`endif
        ext = '0;
        for (int i = 0; i < 31; i++) begin
            ext[i] = hist[30-i];
        end
        ext[W+30:31] = stream;

        err_vec = '0;
        err_cnt = '0;
        for (int p = 0; p < W; p++) begin
            err_vec[p] = ext[p+31] ^ ext[p+3] ^ ext[p];
            err_cnt    = err_cnt + {6'd0, err_vec[p]};
        end
        word_err = |err_vec;

        // An all-zero stream satisfies the parity relation, so it is flagged explicitly.
        if (stream == '0) begin
            err_cnt  = 7'(W);
            word_err = 1'b1;
        end

        for (int j = 0; j < 31; j++) begin
            hist_next[j] = stream[W-1-j];
        end

        sum = {1'b0, prbs_err_total} + (ERR_CNT_WIDTH+1)'(err_cnt);
        total_next = sum[ERR_CNT_WIDTH] ? '1 : sum[ERR_CNT_WIDTH-1:0];
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state                <= ST_UNLOCKED;
            hist                 <= '0;
            primed               <= 1'b0;
            good_cnt             <= '0;
            bad_cnt              <= '0;
            prbs_lock            <= 1'b0;
            prbs_word_error      <= 1'b0;
            prbs_bit_error_count <= '0;
            prbs_err_total       <= '0;
        end else begin
            if (cfg_err_clear) begin
                prbs_err_total <= '0;
            end else if (cfg_rx_prbs31_enable && primed && state == ST_LOCKED) begin
                prbs_err_total <= total_next;
            end

            if (!cfg_rx_prbs31_enable) begin
                state                <= ST_UNLOCKED;
                hist                 <= '0;
                primed               <= 1'b0;
                good_cnt             <= '0;
                bad_cnt              <= '0;
                prbs_lock            <= 1'b0;
                prbs_word_error      <= 1'b0;
                prbs_bit_error_count <= '0;
            end else if (!primed) begin
                hist                 <= hist_next;
                primed               <= 1'b1;
                prbs_word_error      <= 1'b0;
                prbs_bit_error_count <= '0;
            end else begin
                hist                 <= hist_next;
                prbs_word_error      <= word_err;
                prbs_bit_error_count <= err_cnt;
                case (state)
                    ST_UNLOCKED: begin
                        if (word_err) begin
                            good_cnt <= '0;
                        end else if (good_cnt == 8'(LOCK_CNT - 1)) begin
                            state     <= ST_LOCKED;
                            prbs_lock <= 1'b1;
                            good_cnt  <= '0;
                            bad_cnt   <= '0;
                        end else begin
                            good_cnt <= good_cnt + 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!word_err) begin
                            bad_cnt <= '0;
                        end else if (bad_cnt == 8'(UNLOCK_CNT - 1)) begin
                            state     <= ST_UNLOCKED;
                            prbs_lock <= 1'b0;
                            good_cnt  <= '0;
                            bad_cnt   <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state     <= ST_UNLOCKED;
                        prbs_lock <= 1'b0;
                        good_cnt  <= '0;
                        bad_cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/eth_phy_10g_rx_prbs31_check.md
Name: eth_phy_10g_rx_prbs31_check

Overview:
Receive-side PRBS31 checker for the 10GBASE-R PHY. It is the counterpart of the PHY's PRBS31 transmit generator that is enabled by cfg_tx_prbs31_enable. It sits on the raw 66-bit SERDES receive path (serdes_rx_hdr + serdes_rx_data) ahead of block lock and descrambling. It self-synchronises to an x^31 + x^28 + 1 stream, tracks pattern lock with a hysteresis FSM, and reports per-word and accumulated bit-error counts.

Parameters:
DATA_WIDTH, 64, SERDES data width; only 64 is supported.
HDR_WIDTH, 2, sync-header width; only 2 is supported.
LOCK_CNT, 16, consecutive error-free words required to enter LOCKED; range 1..255.
UNLOCK_CNT, 4, consecutive errored words required to leave LOCKED; range 1..255.
ERR_CNT_WIDTH, 32, width of the saturating total bit-error counter.

Ports:
rx_clk  input  1  receive clock; all logic is on its rising edge.
rx_rst  input  1  synchronous, active-high reset.
cfg_rx_prbs31_enable  input  1  checker enable; held static in normal use.
cfg_err_clear  input  1  single-cycle pulse that clears prbs_err_total.
serdes_rx_data  input  64  received data; one 66-bit word arrives every cycle.
serdes_rx_hdr  input  2  received sync header.
prbs_lock  output  1  high while the FSM is in LOCKED.
prbs_word_error  output  1  pulses for one cycle when the checked word contained at least one error.
prbs_bit_error_count  output  7  number of bit errors in the checked word, 0..66.
prbs_err_total  output  ERR_CNT_WIDTH  saturating sum of bit errors counted while LOCKED.

Behaviour:
- Serial bit order per word: hdr[0], hdr[1], data[0] … data[63]. Stream position p = 0..65.
- History register h[30:0] holds the last 31 stream bits, with h[0] the most recent. It updates every enabled cycle with bits 35..65 of the current word.
- Error bit per position: e[p] = b[p] ^ b[p-28] ^ b[p-31]. Bits with negative index come from h. All 66 terms are evaluated combinationally in one cycle.
- Zero-word rule: a word whose 66 bits are all zero is an errored word with a count of 66, because the all-zero stream passes the parity check.
- Warm-up: the first enabled word after reset or after enable rises only loads h. It produces no error, count or FSM update.
- Latency: the outputs prbs_word_error and prbs_bit_error_count are registered. They reflect the word sampled on the previous edge (1 cycle).
- FSM states:
  - UNLOCKED: good_cnt increments on each error-free word and resets to 0 on an errored word. When good_cnt reaches LOCK_CNT, go to LOCKED and clear the counters.
  - LOCKED: bad_cnt increments on each errored word and resets to 0 on an error-free word. When bad_cnt reaches UNLOCK_CNT, go to UNLOCKED and clear the counters.
- prbs_lock rises on the same edge that the FSM enters LOCKED.
- prbs_err_total accumulation:
  - Adds prbs_bit_error_count only on words checked while the FSM was in LOCKED, including the word that triggers unlock.
  - Saturates at all-ones; no wrap-around.
- cfg_err_clear with a simultaneous add: clear wins, and the total becomes 0 on that edge (the add is discarded).
- cfg_rx_prbs31_enable low:
  - h, the FSM (forced to UNLOCKED), good_cnt, bad_cnt and the per-word outputs are held at their reset values.
  - prbs_err_total keeps its value.
  - Re-enabling restarts warm-up.
- Reset: every register is cleared. Reset values are prbs_lock=0, prbs_word_error=0, prbs_bit_error_count=0, prbs_err_total=0, FSM=UNLOCKED, h=0, warm-up pending.
- Reset asserted mid-stream takes priority over every other event on that edge.

Optional Feature:
PRBS31_CHK_INVERT_EN
- Defined: every incoming bit is inverted before checking and before loading h. This matches a transmitter that emits the inverted PRBS31 sequence.
- Undefined: bits are checked as received. An inverted stream then yields errors on every position and never locks.

Test Plan:
- Enable, drive 20 words of a clean PRBS31 stream (seed 0x7FFFFFFF) -> warm-up word, prbs_lock=1 after the 16th checked word (cycle 17+1 latency), prbs_err_total=0.
- Locked stream, flip data[0] (p=2) in one word -> that word reports prbs_bit_error_count=3 (p=2,30,33) and prbs_word_error=1; lock is held; prbs_err_total=3.
- Locked, 4 consecutive words of random data -> prbs_lock falls on the 4th errored word; prbs_err_total includes all 4 counts; 3 errored words followed by 1 clean word keeps lock.
- All-zero input for 30 words -> prbs_word_error=1 every checked cycle, count=66, prbs_lock never rises.
- Set prbs_err_total near saturation with ERR_CNT_WIDTH=8, inject errors -> sticks at 0xFF. Pulse cfg_err_clear in the same cycle as a 3-error word -> total=0.
- Drop enable mid-lock for 2 cycles, then raise it -> prbs_lock=0 immediately and total is retained. Warm-up word is followed by relock after 16 clean words. Assert rx_rst mid-lock -> all outputs 0 on the next edge.
